// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter with registered mux select and a per-grant
// hold timeout that force-releases a requester that never finishes.
module bus_arbiter4 #(
  parameter int SELECT_SIZE = 2,
  parameter int MAX_HOLD    = 16,
  parameter int CNT_WIDTH   = $clog2(MAX_HOLD)
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [3:0]             req_i,
  input  logic                   done_i,
  output logic [SELECT_SIZE-1:0] select_o,
  output logic [3:0]             grant_o,
  output logic                   grant_valid_o,
  output logic                   timeout_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  logic [0:0]             state_reg, state_next;
  logic [SELECT_SIZE-1:0] sel_reg, sel_next;
  logic [SELECT_SIZE-1:0] last_reg, last_next;
  logic [3:0]             grant_reg, grant_next;
  logic                   valid_reg, valid_next;
  logic                   timeout_reg, timeout_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

  logic [SELECT_SIZE-1:0] base_idx;
  logic [SELECT_SIZE-1:0] cand_idx [4];
  logic [3:0]             cand_req;
  logic                   win_found;
  logic [SELECT_SIZE-1:0] win_idx;
  logic                   owner_req;
  logic                   hit_max;

  // While granted, the current owner is the pointer the search rotates from.
  assign base_idx = (state_reg == ST_GRANT) ? sel_reg : last_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand_idx[gi] = base_idx + SELECT_SIZE'(gi + 1);
    assign cand_req[gi] = req_i[cand_idx[gi]];
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = base_idx;
    for (int k = 3; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign owner_req = req_i[sel_reg];
  assign hit_max   = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    last_next    = last_reg;
    grant_next   = grant_reg;
    valid_next   = valid_reg;
    timeout_next = 1'b0;
    cnt_next     = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          state_next = ST_GRANT;
          sel_next   = win_idx;
          grant_next = 4'b0001 << win_idx;
          valid_next = 1'b1;
          cnt_next   = '0;
        end
      end
      default: begin
        cnt_next = cnt_reg + CNT_WIDTH'(1);
        if (done_i || !owner_req || hit_max) begin
          last_next = sel_reg;
          // Only a release forced purely by the hold limit counts as a timeout.
          timeout_next = hit_max && !done_i && owner_req;
          cnt_next     = '0;
          if (win_found) begin
            sel_next   = win_idx;
            grant_next = 4'b0001 << win_idx;
            valid_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
            grant_next = 4'b0000;
            valid_next = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg   <= ST_IDLE;
      sel_reg     <= '0;
      last_reg    <= '1;
      grant_reg   <= 4'b0000;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      last_reg    <= last_next;
      grant_reg   <= grant_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign select_o      = sel_reg;
  assign grant_o       = grant_reg;
  assign grant_valid_o = valid_reg;
  assign timeout_o     = timeout_reg;

endmodule
